// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter, one digit per clock,
// most significant digit first (acc = acc*10 + digit).
// Build option SEG7_IN_EN: digits arrive as active-low 7-segment codes on
// seg_in (bit 7k+0 = a .. 7k+6 = g) and are decoded before the shift register;
// without it, packed BCD on bcd_in is used directly.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// CONV  | accumulating one digit per cycle, NDIG cycles
// DONE  | result registered, valid high for this single cycle
module bcd_to_bin_seq #(
    parameter int NDIG = 2,
    parameter int OUT  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef SEG7_IN_EN
    input  logic [7*NDIG-1:0]   seg_in,
`else
    input  logic [4*NDIG-1:0]   bcd_in,
`endif
    output logic                busy,
    output logic                valid,
    output logic [OUT-1:0]      bin_out,
    output logic                err,
    output logic                ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int AW = OUT + 4;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [AW-1:0] LIMIT = {{4{1'b0}}, {OUT{1'b0}}} | ({{(AW-1){1'b0}}, 1'b1} << OUT);
    localparam logic [AW-1:0] SAT   = LIMIT - {{(AW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_START = IW'(NDIG - 1);

    logic [1:0]        state;
    logic [4*NDIG-1:0] digits_in;
    logic [4*NDIG-1:0] sr;
    logic [IW-1:0]     idx;
    logic [AW-1:0]     acc;
    logic              err_w;
    logic              ovf_w;

    logic [3:0]        cur_dig;
    logic              dig_ok;
    logic [AW-1:0]     acc_mul;
    logic [AW-1:0]     acc_nxt;
    logic              err_nxt;
    logic              ovf_nxt;

`ifdef SEG7_IN_EN
    // Accepts 6, 7 and 9 with or without their optional tail segment.
    function automatic logic [3:0] seg_to_bcd(input logic [6:0] s);
        case (s)
            7'h40:        seg_to_bcd = 4'd0;
            7'h79:        seg_to_bcd = 4'd1;
            7'h24:        seg_to_bcd = 4'd2;
            7'h30:        seg_to_bcd = 4'd3;
            7'h19:        seg_to_bcd = 4'd4;
            7'h12:        seg_to_bcd = 4'd5;
            7'h02, 7'h03: seg_to_bcd = 4'd6;
            7'h78, 7'h58: seg_to_bcd = 4'd7;
            7'h00:        seg_to_bcd = 4'd8;
            7'h10, 7'h18: seg_to_bcd = 4'd9;
            default:      seg_to_bcd = 4'hF;
        endcase
    endfunction

    // Decode each segment group into a BCD nibble (invalid -> 4'hF).
    always_comb begin
        digits_in = '0;
        for (int k = 0; k < NDIG; k++) begin
            digits_in[4*k +: 4] = seg_to_bcd(seg_in[7*k +: 7]);
        end
    end
`else
    assign digits_in = bcd_in;
`endif

    // One accumulation step: acc*10 + digit, with invalid-digit and saturation handling.
    always_comb begin
        cur_dig = sr[4*NDIG-1 -: 4];
        dig_ok  = (cur_dig <= 4'd9);
        acc_mul = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, (dig_ok ? cur_dig : 4'd0)};
        err_nxt = err_w | ~dig_ok;
        ovf_nxt = ovf_w | (acc_mul >= LIMIT);
        acc_nxt = ovf_nxt ? SAT : acc_mul;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sr      <= '0;
            idx     <= '0;
            acc     <= '0;
            err_w   <= 1'b0;
            ovf_w   <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        sr    <= digits_in;
                        acc   <= '0;
                        idx   <= IDX_START;
                        err_w <= 1'b0;
                        ovf_w <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc   <= acc_nxt;
                    err_w <= err_nxt;
                    ovf_w <= ovf_nxt;
                    sr    <= sr << 4;
                    idx   <= idx - 1'b1;
                    if (idx == '0) begin
                        state <= S_DONE;
                        valid <= 1'b1;
                        if (err_nxt) begin
                            bin_out <= '0;
                            err     <= 1'b1;
                            ovf     <= 1'b0;
                        end else if (ovf_nxt) begin
                            bin_out <= '1;
                            err     <= 1'b0;
                            ovf     <= 1'b1;
                        end else begin
                            bin_out <= acc_nxt[OUT-1:0];
                            err     <= 1'b0;
                            ovf     <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: a 7-bit-result instance and a 6-bit-result
// instance driven by the same stimulus. With SEG7_IN_EN defined, digits are
// encoded to active-low 7-seg codes and raw segment patterns are also tried.
module tb_bcd_to_bin_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bcd_v;
    logic       busy, valid, err, ovf;
    logic [6:0] bin_out;
    logic       busy6, valid6, err6, ovf6;
    logic [5:0] bin6;
    int         checks;
    int         errors;
    int         lat;
    int         npulse;

`ifdef SEG7_IN_EN
    logic [13:0] seg_v;

    // Encoder: digit -> active-low code, bit0 = a .. bit6 = g; non-digits blank.
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'h40;
            4'd1: enc = 7'h79;
            4'd2: enc = 7'h24;
            4'd3: enc = 7'h30;
            4'd4: enc = 7'h19;
            4'd5: enc = 7'h12;
            4'd6: enc = 7'h02;
            4'd7: enc = 7'h78;
            4'd8: enc = 7'h00;
            4'd9: enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction
`endif

    bcd_to_bin_seq #(.NDIG(2), .OUT(7)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef SEG7_IN_EN
        .seg_in(seg_v),
`else
        .bcd_in(bcd_v),
`endif
        .busy(busy), .valid(valid), .bin_out(bin_out), .err(err), .ovf(ovf)
    );

    bcd_to_bin_seq #(.NDIG(2), .OUT(6)) dut6 (
        .clk(clk), .rst(rst), .start(start),
`ifdef SEG7_IN_EN
        .seg_in(seg_v),
`else
        .bcd_in(bcd_v),
`endif
        .busy(busy6), .valid(valid6), .bin_out(bin6), .err(err6), .ovf(ovf6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dig(input logic [7:0] v);
        bcd_v = v;
`ifdef SEG7_IN_EN
        seg_v = {enc(v[7:4]), enc(v[3:0])};
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Pulse start with digits already applied; stop on valid or after 10 cycles.
    task automatic run_conv(output int l);
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        while (!valid && l < 10) begin
            tick();
            l++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        set_dig(8'h00);

        // Reset state
        tick();
        tick();
        chk("rst_busy",  {31'd0, busy},  0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_bin",   {25'd0, bin_out}, 0);
        chk("rst_err",   {31'd0, err},   0);
        chk("rst_ovf",   {31'd0, ovf},   0);
        rst = 1'b0;
        tick();

        // 42: valid exactly two cycles after the cycle following the start edge
        set_dig(8'h42);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t42_busy_c0",  {31'd0, busy},  1);
        chk("t42_valid_c0", {31'd0, valid}, 0);
        tick();
        chk("t42_valid_c1", {31'd0, valid}, 0);
        tick();
        chk("t42_valid_c2", {31'd0, valid}, 1);
        chk("t42_bin",      {25'd0, bin_out}, 42);
        chk("t42_err",      {31'd0, err}, 0);
        chk("t42_ovf",      {31'd0, ovf}, 0);
        chk("t42_bin6",     {26'd0, bin6}, 42);
        tick();
        chk("t42_valid_c3", {31'd0, valid}, 0);
        chk("t42_busy_c3",  {31'd0, busy},  0);
        chk("t42_hold",     {25'd0, bin_out}, 42);

        // 99 then 00 with start held: pulses 4 cycles apart
        set_dig(8'h99);
        start = 1'b1;
        tick();
        set_dig(8'h00);
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 4) start = 1'b0;
            chk($sformatf("b2b_valid_%0d", i), {31'd0, valid}, ((i == 2) || (i == 6)) ? 1 : 0);
            if (i == 2) begin
                chk("b2b_bin99",  {25'd0, bin_out}, 99);
                chk("b2b_bin6",   {26'd0, bin6}, 63);
                chk("b2b_ovf6",   {31'd0, ovf6}, 1);
            end
            if (i == 6) begin
                chk("b2b_bin00",  {25'd0, bin_out}, 0);
                chk("b2b_ovf6_0", {31'd0, ovf6}, 0);
            end
        end
        chk("b2b_busy_end", {31'd0, busy}, 0);

        // 3A: invalid units digit, plus a start pulse mid-conversion
        set_dig(8'h3A);
        start = 1'b1;
        tick();
        npulse = 0;
        for (int i = 1; i <= 6; i++) begin
            start = (i == 1);
            tick();
            if (valid) npulse++;
            if (i == 2) begin
                chk("t3a_valid", {31'd0, valid}, 1);
                chk("t3a_err",   {31'd0, err}, 1);
                chk("t3a_bin",   {25'd0, bin_out}, 0);
                chk("t3a_ovf",   {31'd0, ovf}, 0);
            end
        end
        start = 1'b0;
        chk("t3a_pulses", npulse, 1);

        // 9A on OUT=6: overflow on the way, but err wins
        set_dig(8'h9A);
        run_conv(lat);
        chk("t9a_lat",  lat, 3);
        chk("t9a_err6", {31'd0, err6}, 1);
        chk("t9a_ovf6", {31'd0, ovf6}, 0);
        chk("t9a_bin6", {26'd0, bin6}, 0);
        tick();

        // Boundary at 2**6 on OUT=6
        set_dig(8'h64);
        run_conv(lat);
        chk("t64_lat",  lat, 3);
        chk("t64_bin6", {26'd0, bin6}, 63);
        chk("t64_ovf6", {31'd0, ovf6}, 1);
        chk("t64_bin",  {25'd0, bin_out}, 64);
        chk("t64_ovf",  {31'd0, ovf}, 0);
        tick();
        set_dig(8'h63);
        run_conv(lat);
        chk("t63_bin6", {26'd0, bin6}, 63);
        chk("t63_ovf6", {31'd0, ovf6}, 0);
        tick();

        // Reset during CONV: abort, outputs back to reset values, no pulse
        set_dig(8'h55);
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_bin",  {25'd0, bin_out}, 0);
        chk("abort_bin6", {26'd0, bin6}, 0);
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid) npulse++;
        end
        chk("abort_pulses", npulse, 0);

        // rst and start together: rst wins
        set_dig(8'h12);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 0);
        tick();
        chk("rst_start_busy2", {31'd0, busy}, 0);

`ifdef SEG7_IN_EN
        // '5' and '7' from raw segment codes
        seg_v = {7'h12, 7'h78};
        run_conv(lat);
        chk("seg57_bin", {25'd0, bin_out}, 57);
        chk("seg57_err", {31'd0, err}, 0);
        tick();
        // 9 without d, 7 with f
        seg_v = {7'h18, 7'h58};
        run_conv(lat);
        chk("seg97_bin", {25'd0, bin_out}, 97);
        tick();
        // Blank units digit
        seg_v = {7'h12, 7'h7F};
        run_conv(lat);
        chk("segblank_err", {31'd0, err}, 1);
        chk("segblank_bin", {25'd0, bin_out}, 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
